// File: rtl/fl_pkg.sv
// Shared defaults and helpers for the superscalar free list.
// Default configuration: 32 entries, 6-bit preg tags, 2 dispatch and 2 retire ports.
package fl_pkg;

  localparam int FL_DEPTH_DEF = 32;
  localparam int PREG_W_DEF   = 6;
  localparam int DISP_W_DEF   = 2;
  localparam int RET_W_DEF    = 2;
  localparam int PTR_W_DEF    = $clog2(FL_DEPTH_DEF) + 1;

  typedef logic [PTR_W_DEF-1:0]  fl_ptr_t;
  typedef logic [PREG_W_DEF-1:0] preg_t;

  // Number of set bits in a request vector (callers zero-extend to 32 bits).
  function automatic int popcount(input logic [31:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) c++;
    end
    return c;
  endfunction

endpackage

// File: rtl/fl_offer_sel.sv
// Combinational offer selection for the free list.
// The logical stream is the stored entries from head followed by this cycle's
// retire slots; dispatch slot k is offered stream[k]. With FL_BYPASS_EN the
// retire slots may be granted in the same cycle, otherwise only stored entries
// are valid.
module fl_offer_sel
  import fl_pkg::*;
#(
  parameter int PREG_W = PREG_W_DEF,
  parameter int DISP_W = DISP_W_DEF,
  parameter int RET_W  = RET_W_DEF,
  parameter int PTR_W  = PTR_W_DEF
) (
  input  logic [DISP_W*PREG_W-1:0] stored_preg,
  input  logic [PTR_W-1:0]         free_cnt,
  input  logic [RET_W-1:0]         retire_en,
  input  logic [RET_W*PREG_W-1:0]  retire_preg,
  input  logic                     recover_en,
  input  logic [DISP_W-1:0]        dispatch_en,
  output logic [DISP_W-1:0]        free_preg_vld,
  output logic [DISP_W*PREG_W-1:0] free_preg,
  output logic [PTR_W-1:0]         n_disp,
  output logic [PTR_W-1:0]         n_byp
);

  int cnt_int;
  int n_ret;
  int n_disp_int;

  // Build the offered stream, slot valids, grant count and the bypass count.
  always_comb begin
    cnt_int       = int'(free_cnt);
    n_ret         = popcount(32'(retire_en));
    free_preg_vld = '0;
    free_preg     = '0;
    for (int k = 0; k < DISP_W; k++) begin
      if (k < cnt_int) begin
        free_preg[k*PREG_W +: PREG_W] = stored_preg[k*PREG_W +: PREG_W];
      end else if ((k - cnt_int) < n_ret) begin
        free_preg[k*PREG_W +: PREG_W] = retire_preg[(k - cnt_int)*PREG_W +: PREG_W];
      end
`ifdef FL_BYPASS_EN
      free_preg_vld[k] = !recover_en && (k < (cnt_int + n_ret));
`else
      free_preg_vld[k] = !recover_en && (k < cnt_int);
`endif
    end
    n_disp_int = popcount(32'(dispatch_en & free_preg_vld));
    n_disp     = PTR_W'(n_disp_int);
`ifdef FL_BYPASS_EN
    n_byp = (n_disp_int > cnt_int) ? PTR_W'(n_disp_int - cnt_int) : '0;
`else
    n_byp = '0;
`endif
  end

endmodule

// File: rtl/free_list_ss.sv
// Superscalar physical-register free list: a circular FIFO of free preg tags.
// Hands up to DISP_W tags to rename per cycle, accepts up to RET_W stale tags
// from retire per cycle, and restores head in one cycle on branch recovery.
// Optional macro FL_BYPASS_EN enables same-cycle retire-to-dispatch bypass.
module free_list_ss
  import fl_pkg::*;
#(
  parameter  int FL_DEPTH = FL_DEPTH_DEF,
  parameter  int PREG_W   = PREG_W_DEF,
  parameter  int DISP_W   = DISP_W_DEF,
  parameter  int RET_W    = RET_W_DEF,
  localparam int IDX_W    = $clog2(FL_DEPTH),
  localparam int PTR_W    = IDX_W + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DISP_W-1:0]        dispatch_en_i,
  input  logic [RET_W-1:0]         retire_en_i,
  input  logic [RET_W*PREG_W-1:0]  retire_preg_i,
  input  logic                     recover_en_i,
  input  logic [PTR_W-1:0]         recover_head_i,
  output logic [DISP_W-1:0]        free_preg_vld_o,
  output logic [DISP_W*PREG_W-1:0] free_preg_o,
  output logic [PTR_W-1:0]         free_preg_cur_head_o,
  output logic [IDX_W:0]           free_cnt_o,
  output logic [PTR_W-1:0]         head_o,
  output logic [PTR_W-1:0]         tail_o
);

  logic [PREG_W-1:0]        mem [FL_DEPTH];
  logic [PTR_W-1:0]         head;
  logic [PTR_W-1:0]         tail;
  logic [PTR_W-1:0]         head_next;
  logic [PTR_W-1:0]         tail_next;
  logic [PTR_W-1:0]         free_cnt;
  logic [PTR_W-1:0]         n_disp;
  logic [PTR_W-1:0]         n_byp;
  logic [PTR_W-1:0]         n_ret;
  logic [PTR_W-1:0]         n_wr;
  logic [PTR_W-1:0]         n_wr_ok;
  logic [PTR_W-1:0]         space;
  logic [DISP_W*PREG_W-1:0] stored_preg;

  assign free_cnt             = tail - head;
  assign free_cnt_o           = free_cnt;
  assign free_preg_cur_head_o = head;
  assign head_o               = head;
  assign tail_o               = tail;

  // Read the DISP_W stored entries starting at head (index wraps naturally).
  always_comb begin
    stored_preg = '0;
    for (int k = 0; k < DISP_W; k++) begin
      stored_preg[k*PREG_W +: PREG_W] = mem[head[IDX_W-1:0] + IDX_W'(k)];
    end
  end

  fl_offer_sel #(
    .PREG_W (PREG_W),
    .DISP_W (DISP_W),
    .RET_W  (RET_W),
    .PTR_W  (PTR_W)
  ) u_offer_sel (
    .stored_preg   (stored_preg),
    .free_cnt      (free_cnt),
    .retire_en     (retire_en_i),
    .retire_preg   (retire_preg_i),
    .recover_en    (recover_en_i),
    .dispatch_en   (dispatch_en_i),
    .free_preg_vld (free_preg_vld_o),
    .free_preg     (free_preg_o),
    .n_disp        (n_disp),
    .n_byp         (n_byp)
  );

  // Next pointers: bypassed retires neither pop storage nor get written, and
  // writes beyond the room left after the head move are dropped.
  always_comb begin
    n_ret     = PTR_W'(popcount(32'(retire_en_i)));
    n_wr      = n_ret - n_byp;
    head_next = recover_en_i ? recover_head_i : head + (n_disp - n_byp);
    space     = PTR_W'(FL_DEPTH) - (tail - head_next);
    n_wr_ok   = (n_wr > space) ? space : n_wr;
    tail_next = tail + n_wr_ok;
  end

  // Storage and pointer registers; reset fills the list with FL_DEPTH..2*FL_DEPTH-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= PTR_W'(FL_DEPTH);
      for (int i = 0; i < FL_DEPTH; i++) begin
        mem[i] <= PREG_W'(FL_DEPTH + i);
      end
    end else begin
      head <= head_next;
      tail <= tail_next;
      for (int j = 0; j < RET_W; j++) begin
        if (PTR_W'(j) < n_wr_ok) begin
          mem[tail[IDX_W-1:0] + IDX_W'(j)] <= retire_preg_i[(int'(n_byp) + j)*PREG_W +: PREG_W];
        end
      end
    end
  end

  // Retiring into a full list is a protocol error upstream; flag it in simulation.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (n_wr <= space)
      else $error("free_list_ss: retire into full free list, write dropped");
    end
  end

endmodule

// File: tb/tb_free_list_ss.sv
// Self-checking bench for free_list_ss: directed steps followed by random
// traffic, all compared against a queue-based model of the free list.
module tb_free_list_ss;
  import fl_pkg::*;

  localparam int DEPTH = 32;
  localparam int PW    = 6;
  localparam int DW    = 2;
  localparam int RW    = 2;
  localparam int PTRW  = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   dispatch_en_i;
  logic [RW-1:0]   retire_en_i;
  logic [RW*PW-1:0] retire_preg_i;
  logic            recover_en_i;
  logic [PTRW-1:0] recover_head_i;
  logic [DW-1:0]   free_preg_vld_o;
  logic [DW*PW-1:0] free_preg_o;
  logic [PTRW-1:0] free_preg_cur_head_o;
  logic [PTRW-1:0] free_cnt_o;
  logic [PTRW-1:0] head_o;
  logic [PTRW-1:0] tail_o;

  always #5 clk = ~clk;

  free_list_ss dut (
    .clk                  (clk),
    .rst                  (rst),
    .dispatch_en_i        (dispatch_en_i),
    .retire_en_i          (retire_en_i),
    .retire_preg_i        (retire_preg_i),
    .recover_en_i         (recover_en_i),
    .recover_head_i       (recover_head_i),
    .free_preg_vld_o      (free_preg_vld_o),
    .free_preg_o          (free_preg_o),
    .free_preg_cur_head_o (free_preg_cur_head_o),
    .free_cnt_o           (free_cnt_o),
    .head_o               (head_o),
    .tail_o               (tail_o)
  );

  // Reference model: free tags in order, plus a log of tags popped from storage
  // so a recovery can put them back in front.
  int q[$];
  int pop_log[$];
  int head_m;
  int tail_m;
  int ckpt_head[$];
  int ckpt_log[$];
  int checks = 0;
  int passed = 0;

  logic [1:0] exp_vld;
  int stream[$];
  int n_disp_m;
  int n_byp_m;
  int n_ret_m;
  int ret_vals[RW];

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic resetModel();
    q = {};
    for (int i = 0; i < DEPTH; i++) q.push_back(DEPTH + i);
    pop_log   = {};
    head_m    = 0;
    tail_m    = DEPTH;
    ckpt_head = {};
    ckpt_log  = {};
  endtask

  task automatic applyStimulus(input logic [1:0] disp, input logic [1:0] ren, input int p0,
                               input int p1, input logic rec, input int rh);
    dispatch_en_i  = disp;
    retire_en_i    = ren;
    retire_preg_i  = {PW'(p1), PW'(p0)};
    recover_en_i   = rec;
    recover_head_i = PTRW'(rh);
  endtask

  // Expected offer for the current inputs, from the stream rule.
  task automatic predict();
    int lim;
    n_ret_m = 0;
    for (int r = 0; r < RW; r++) begin
      ret_vals[r] = int'(retire_preg_i[r*PW +: PW]);
      if (retire_en_i[r]) n_ret_m++;
    end
    stream = q;
    for (int r = 0; r < n_ret_m; r++) stream.push_back(ret_vals[r]);
`ifdef FL_BYPASS_EN
    lim = q.size() + n_ret_m;
`else
    lim = q.size();
`endif
    n_disp_m = 0;
    for (int k = 0; k < DW; k++) begin
      exp_vld[k] = !recover_en_i && (k < lim);
      if (dispatch_en_i[k] && exp_vld[k]) n_disp_m++;
    end
`ifdef FL_BYPASS_EN
    n_byp_m = (n_disp_m > q.size()) ? n_disp_m - q.size() : 0;
`else
    n_byp_m = 0;
`endif
  endtask

  task automatic checkOutput();
    predict();
    checkValue("vld", 32'(free_preg_vld_o), 32'(exp_vld));
    for (int k = 0; k < DW; k++) begin
      if (exp_vld[k]) checkValue($sformatf("preg%0d", k), 32'(free_preg_o[k*PW +: PW]), stream[k]);
    end
    checkValue("cnt", 32'(free_cnt_o), q.size());
    checkValue("head", 32'(head_o), head_m);
    checkValue("cur_head", 32'(free_preg_cur_head_o), head_m);
    checkValue("tail", 32'(tail_o), tail_m);
  endtask

  task automatic modelAdvance();
    int pops;
    int d;
    pops = n_disp_m - n_byp_m;
    for (int i = 0; i < pops; i++) pop_log.push_back(q.pop_front());
    head_m = (head_m + pops) % 64;
    if (recover_en_i) begin
      d = (head_m - int'(recover_head_i) + 64) % 64;
      for (int i = 0; i < d; i++) q.push_front(pop_log.pop_back());
      head_m = int'(recover_head_i);
    end
    for (int r = n_byp_m; r < n_ret_m; r++) begin
      q.push_back(ret_vals[r]);
      tail_m = (tail_m + 1) % 64;
    end
  endtask

  task automatic stepCycle(input logic [1:0] disp, input logic [1:0] ren, input int p0,
                           input int p1, input logic rec, input int rh);
    @(negedge clk);
    applyStimulus(disp, ren, p0, p1, rec, rh);
    #1;
    checkOutput();
    @(posedge clk);
    modelAdvance();
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int nd, nr, pick, pcount, rh;
    logic rec;

    // Reset and its visible state.
    rst = 1'b1;
    applyStimulus(2'b00, 2'b00, 0, 0, 1'b0, 0);
    resetModel();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checkValue("rst_vld", 32'(free_preg_vld_o), 32'(2'b11));
    checkValue("rst_preg", 32'(free_preg_o), 32'({6'd33, 6'd32}));
    checkValue("rst_cnt", 32'(free_cnt_o), 32);
    checkValue("rst_tail", 32'(tail_o), 32);
    stepCycle(2'b00, 2'b00, 0, 0, 1'b0, 0);

    // Drain everything two per cycle.
    repeat (16) stepCycle(2'b11, 2'b00, 0, 0, 1'b0, 0);
    checkValue("drain_head", 32'(head_o), 32);
    checkValue("drain_cnt", 32'(free_cnt_o), 0);
    checkValue("drain_vld", 32'(free_preg_vld_o), 0);

    // Refill with tags 0..31.
    for (int i = 0; i < 16; i++) stepCycle(2'b00, 2'b11, 2*i, 2*i+1, 1'b0, 0);
    checkValue("refill_cnt", 32'(free_cnt_o), 32);
    checkValue("refill_tail", 32'(tail_o), 0);
    checkValue("refill_preg", 32'(free_preg_o), 32'({6'd1, 6'd0}));

    // Dispatch three cycles then recover to the checkpoint after the first.
    repeat (3) stepCycle(2'b11, 2'b00, 0, 0, 1'b0, 0);
    stepCycle(2'b11, 2'b00, 0, 0, 1'b1, 34);
    checkValue("rec_head", 32'(head_o), 34);
    checkValue("rec_cnt", 32'(free_cnt_o), 30);
    checkValue("rec_preg", 32'(free_preg_o), 32'({6'd3, 6'd2}));

    // Empty-list bypass.
    for (int g = 0; g < 40 && q.size() > 0; g++) stepCycle(2'b11, 2'b00, 0, 0, 1'b0, 0);
    stepCycle(2'b11, 2'b11, 25, 26, 1'b0, 0);
    stepCycle(2'b00, 2'b00, 0, 0, 1'b0, 0);

    // Partial bypass: one stored tag (7) plus retires 40, 41.
    for (int g = 0; g < 40 && q.size() > 0; g++) stepCycle(2'b11, 2'b00, 0, 0, 1'b0, 0);
    stepCycle(2'b00, 2'b01, 7, 0, 1'b0, 0);
    stepCycle(2'b11, 2'b11, 40, 41, 1'b0, 0);
    stepCycle(2'b00, 2'b00, 0, 0, 1'b0, 0);

    // Reset in the middle of traffic, observed before any clock edge.
    stepCycle(2'b01, 2'b01, 12, 0, 1'b0, 0);
    stepCycle(2'b01, 2'b00, 0, 0, 1'b0, 0);
    @(negedge clk);
    applyStimulus(2'b00, 2'b00, 0, 0, 1'b0, 0);
    #2;
    rst = 1'b1;
    #1;
    checkValue("arst_vld", 32'(free_preg_vld_o), 32'(2'b11));
    checkValue("arst_preg", 32'(free_preg_o), 32'({6'd33, 6'd32}));
    checkValue("arst_cnt", 32'(free_cnt_o), 32);
    checkValue("arst_head", 32'(head_o), 0);
    checkValue("arst_tail", 32'(tail_o), 32);
    resetModel();
    @(negedge clk);
    rst = 1'b0;

    // Random traffic with occasional recovery to a recorded checkpoint.
    for (int c = 0; c < 400; c++) begin
      nd  = $urandom_range(0, 2);
      nr  = $urandom_range(0, 2);
      if (nr > DEPTH - q.size()) nr = DEPTH - q.size();
      rec = 1'b0;
      rh  = 0;
      if (ckpt_head.size() > 0 && $urandom_range(0, 7) == 0) begin
        pick   = $urandom_range(0, ckpt_head.size() - 1);
        pcount = pop_log.size() - ckpt_log[pick];
        if (q.size() + pcount <= DEPTH) begin
          rec = 1'b1;
          rh  = ckpt_head[pick];
          if (nr > DEPTH - q.size() - pcount) nr = DEPTH - q.size() - pcount;
          ckpt_head = {};
          ckpt_log  = {};
        end
      end else if ($urandom_range(0, 3) == 0) begin
        ckpt_head.push_back(head_m);
        ckpt_log.push_back(pop_log.size());
        if (ckpt_head.size() > 4) begin
          void'(ckpt_head.pop_front());
          void'(ckpt_log.pop_front());
        end
      end
      stepCycle(2'((1 << nd) - 1), 2'((1 << nr) - 1), $urandom_range(0, 63),
                $urandom_range(0, 63), rec, rh);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
